cla16_adder: RTL and testbench
==============================

# cla16_adder

Registered 16-bit carry-lookahead adder. Adds two 16-bit operands plus carry-in using a two-level lookahead tree of 4-bit groups. Outputs the sum, carry-out and block-level group propagate/generate; all outputs are registered. Serves as the datapath adder and as a cascadable CLA block, with PG/GG feeding a higher-level lookahead unit.

## Interface
Parameters:
- none (width fixed at 16, organized as 4 groups of 4 bits)

Ports:
- clk  input  1  rising-edge clock; the design's only clock
- rst_n  input  1  asynchronous, active-low reset
- A  input  16  operand A
- B  input  16  operand B
- Ci  input  1  carry-in
- S  output  16  registered sum, (A + B + Ci) mod 2^16
- Co  output  1  registered carry-out, bit 16 of A + B + Ci
- PG  output  1  registered block group propagate
- GG  output  1  registered block group generate

## Operation
- Bit level: p_i = A[i] ^ B[i], g_i = A[i] & B[i]. S[i] = p_i ^ c_i, with c_0 = Ci.
- Group level (k = 0..3, bits 4k..4k+3):
  - Group propagate P_k = AND of its four p_i.
  - Group generate G_k = g3 | p3g2 | p3p2g1 | p3p2p1g0 (local indices).
- Lookahead unit:
  - C_4 = G_0 | P_0·Ci
  - C_8 = G_1 | P_1·G_0 | P_1·P_0·Ci
  - C_12 and C_16 follow the same expansion.
  - All expansions are flat sum-of-products; no ripple between groups.
- Block outputs:
  - PG = P_3·P_2·P_1·P_0, i.e. all 16 bits are propagate.
  - GG = G_3 | P_3G_2 | P_3P_2G_1 | P_3P_2P_1G_0.
  - Co = GG | PG·Ci.
- PG and GG are independent of Ci.
- {Co, S} equals the full 17-bit sum A + B + Ci for every input combination. Unsigned arithmetic; no overflow flag.

## Timing
- Combinational core computes from the current A, B, Ci. S, Co, PG, GG are captured on each rising clk edge.
- Latency: exactly 1 cycle. Inputs stable before edge n produce results on the outputs after edge n.
- Throughput: one addition per cycle. No handshake; a new result is produced every cycle.
- Reset: rst_n low immediately forces S=16'h0000, Co=0, PG=0, GG=0 without waiting for clk. Outputs stay there while rst_n is low.
- Release of rst_n: the first rising edge with rst_n high loads the live sum. Reset asserted mid-stream discards the pending result.
- Boundary cases:
  - 0xFFFF + 0x0000 + Ci=1 wraps S to 0x0000 with Co=1.
  - 0xFFFF + 0xFFFF + 1 gives S=0xFFFF, Co=1.
- Core critical path: p/g, then group P/G, then block carries, then sum XOR. Must close within one clock period at the target frequency.

## Structure
- Shared package holds:
  - WIDTH=16
  - GROUP=4
  - NGROUPS=4
- One natural sub-module, cla4: inputs a[3:0], b[3:0], cin; outputs s[3:0], group p, group g.
  - Instantiated 4 times.
  - The top level contains the second-level lookahead equations and the output register.

## Test plan
- Reset: drive rst_n=0 asynchronously between edges with A=0x1234, B=0x4321 → S=0x0000, Co=0, PG=0, GG=0 immediately. Release, then one edge → S=0x5555, Co=0, PG=0, GG=0.
- Carry ripple through all groups: A=0xFFFF, B=0x0001, Ci=0 → next cycle S=0x0000, Co=1, PG=0, GG=1.
- Full propagate: A=0xFFFF, B=0x0000, Ci=1 → S=0x0000, Co=1, PG=1, GG=0. Same with Ci=0 → S=0xFFFF, Co=0, PG=1, GG=0.
- Max operands: A=0xFFFF, B=0xFFFF, Ci=1 → S=0xFFFF, Co=1, PG=0, GG=1. A=0x8000, B=0x8000, Ci=0 → S=0x0000, Co=1.
- Back-to-back pipelining: apply A=0x00FF/B=0x0001, then A=0x0F0F/B=0xF0F0 on consecutive cycles → outputs 0x0100 then 0xFFFF (Co=0, PG=1) on consecutive cycles.
- Random regression: ≥10,000 random A, B, Ci values. Check {Co,S} == A+B+Ci one cycle later. Check PG == &(A^B) and GG against the reference equation.

Source files
------------

// File: rtl/cla16_adder_pkg.sv
// Shared sizing constants for the 16-bit carry-lookahead adder.
// The block is organised as NGROUPS groups of GROUP bits each.
package cla16_adder_pkg;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned GROUP   = 4;
    localparam int unsigned NGROUPS = WIDTH / GROUP;

endpackage

// File: rtl/cla16_adder_cla4.sv
// 4-bit carry-lookahead group: local sum, group propagate and group generate.
// The internal carries are flat sum-of-products so that no carry ripples between bits.
module cla16_adder_cla4
    import cla16_adder_pkg::*;
(
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             p,
    output logic             g
);

    logic [GROUP-1:0] bp;
    logic [GROUP-1:0] bg;
    logic [GROUP-1:0] c;

    always_comb begin
        bp = a ^ b;
        bg = a & b;

        c[0] = cin;
        c[1] = bg[0] | (bp[0] & cin);
        c[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & cin);
        c[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
             | (bp[2] & bp[1] & bp[0] & cin);

        s = bp ^ c;
        p = &bp;
        g = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
          | (bp[3] & bp[2] & bp[1] & bg[0]);
    end

endmodule

// File: rtl/cla16_adder.sv
// Registered 16-bit two-level carry-lookahead adder with block PG/GG outputs
// for cascading into a higher-level lookahead unit.
module cla16_adder
    import cla16_adder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             PG,
    output logic             GG
);

    logic [NGROUPS-1:0] grp_p;
    logic [NGROUPS-1:0] grp_g;
    logic [NGROUPS-1:0] grp_c;
    logic [WIDTH-1:0]   sum_d;
    logic               co_d;
    logic               pg_d;
    logic               gg_d;

    logic [WIDTH-1:0]   s_q;
    logic               co_q;
    logic               pg_q;
    logic               gg_q;

    for (genvar k = 0; k < NGROUPS; k++) begin : g_grp
        cla16_adder_cla4 u_cla4 (
            .a   (A[GROUP*k +: GROUP]),
            .b   (B[GROUP*k +: GROUP]),
            .cin (grp_c[k]),
            .s   (sum_d[GROUP*k +: GROUP]),
            .p   (grp_p[k]),
            .g   (grp_g[k])
        );
    end

    // Second-level lookahead: every group carry-in is a flat expansion of Ci.
    always_comb begin
        grp_c[0] = Ci;
        grp_c[1] = grp_g[0] | (grp_p[0] & Ci);
        grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & Ci);
        grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & Ci);

        pg_d = &grp_p;
        gg_d = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
        co_d = gg_d | (pg_d & Ci);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q  <= '0;
            co_q <= 1'b0;
            pg_q <= 1'b0;
            gg_q <= 1'b0;
        end else begin
            s_q  <= sum_d;
            co_q <= co_d;
            pg_q <= pg_d;
            gg_q <= gg_d;
        end
    end

    assign S  = s_q;
    assign Co = co_q;
    assign PG = pg_q;
    assign GG = gg_q;

endmodule

// File: tb/tb_cla16_adder.sv
// Self-checking bench for cla16_adder: directed boundary cases plus a random
// regression against an arithmetic reference model.
module tb_cla16_adder;

    logic        clk;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic        Ci;
    logic [15:0] S;
    logic        Co;
    logic        PG;
    logic        GG;

    int n_tests;
    int n_fail;

    cla16_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Ci    (Ci),
        .S     (S),
        .Co    (Co),
        .PG    (PG),
        .GG    (GG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the 17-bit sum by plain arithmetic; GG is the block
    // carry-out with carry-in forced to zero, PG means every bit position propagates.
    function automatic logic [18:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic ci);
        logic [16:0] full;
        logic [16:0] no_ci;
        full  = {1'b0, a} + {1'b0, b} + {16'b0, ci};
        no_ci = {1'b0, a} + {1'b0, b};
        return {full, &(a ^ b), no_ci[16]};
    endfunction

    // Drive operands away from the edge, then step to 1 ns past the next rising edge.
    task automatic step(input logic [15:0] a, input logic [15:0] b, input logic ci);
        A  = a;
        B  = b;
        Ci = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        step(16'hAAAA, 16'h1111, 1'b0);
        A = 16'h1234;
        B = 16'h4321;
        Ci = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({Co, S, PG, GG} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_async: got Co=%b S=%h PG=%b GG=%b, want all zero",
                     Co, S, PG, GG);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if ({Co, S, PG, GG} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got Co=%b S=%h PG=%b GG=%b, want all zero",
                     Co, S, PG, GG);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if ({Co, S, PG, GG} !== {1'b0, 16'h5555, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release: got Co=%b S=%h PG=%b GG=%b, want Co=0 S=5555 PG=0 GG=0",
                     Co, S, PG, GG);
        end
    endtask

    task automatic test_ripple();
        step(16'hFFFF, 16'h0001, 1'b0);
        n_tests++;
        if ({Co, S, PG, GG} !== {1'b1, 16'h0000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL ripple: got Co=%b S=%h PG=%b GG=%b, want Co=1 S=0000 PG=0 GG=1",
                     Co, S, PG, GG);
        end
    endtask

    task automatic test_propagate();
        step(16'hFFFF, 16'h0000, 1'b1);
        n_tests++;
        if ({Co, S, PG, GG} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL propagate_ci1: got Co=%b S=%h PG=%b GG=%b, want Co=1 S=0000 PG=1 GG=0",
                     Co, S, PG, GG);
        end
        step(16'hFFFF, 16'h0000, 1'b0);
        n_tests++;
        if ({Co, S, PG, GG} !== {1'b0, 16'hFFFF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL propagate_ci0: got Co=%b S=%h PG=%b GG=%b, want Co=0 S=ffff PG=1 GG=0",
                     Co, S, PG, GG);
        end
    endtask

    task automatic test_max();
        step(16'hFFFF, 16'hFFFF, 1'b1);
        n_tests++;
        if ({Co, S, PG, GG} !== {1'b1, 16'hFFFF, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL max_all_ones: got Co=%b S=%h PG=%b GG=%b, want Co=1 S=ffff PG=0 GG=1",
                     Co, S, PG, GG);
        end
        step(16'h8000, 16'h8000, 1'b0);
        n_tests++;
        if ({Co, S} !== {1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL max_msb: got Co=%b S=%h, want Co=1 S=0000", Co, S);
        end
    endtask

    task automatic test_back_to_back();
        step(16'h00FF, 16'h0001, 1'b0);
        n_tests++;
        if ({Co, S} !== {1'b0, 16'h0100}) begin
            n_fail++;
            $display("FAIL b2b_first: got Co=%b S=%h, want Co=0 S=0100", Co, S);
        end
        step(16'h0F0F, 16'hF0F0, 1'b0);
        n_tests++;
        if ({Co, S, PG} !== {1'b0, 16'hFFFF, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_second: got Co=%b S=%h PG=%b, want Co=0 S=ffff PG=1",
                     Co, S, PG);
        end
    endtask

    task automatic test_reset_midstream();
        step(16'h1000, 16'h2000, 1'b1);
        A = 16'h7777;
        B = 16'h1111;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({Co, S, PG, GG} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got Co=%b S=%h PG=%b GG=%b, want all zero",
                     Co, S, PG, GG);
        end
        #2 rst_n = 1'b1;
        step(16'h7777, 16'h1111, 1'b0);
        n_tests++;
        if ({Co, S} !== {1'b0, 16'h8888}) begin
            n_fail++;
            $display("FAIL reset_mid_release: got Co=%b S=%h, want Co=0 S=8888", Co, S);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [18:0] exp;
        for (int i = 0; i < 10000; i++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            ci = 1'($urandom);
            // Bias a share of cases toward long propagate chains.
            if (i % 8 == 0) b = ~a ^ 16'(1 << $urandom_range(15, 0));
            exp = ref_model(a, b, ci);
            step(a, b, ci);
            n_tests++;
            if ({Co, S} !== exp[18:2]) begin
                n_fail++;
                $display("FAIL rand_sum: A=%h B=%h Ci=%b got %h, want %h",
                         a, b, ci, {Co, S}, exp[18:2]);
            end
            n_tests++;
            if (PG !== exp[1]) begin
                n_fail++;
                $display("FAIL rand_pg: A=%h B=%h got %b, want %b", a, b, PG, exp[1]);
            end
            n_tests++;
            if (GG !== exp[0]) begin
                n_fail++;
                $display("FAIL rand_gg: A=%h B=%h got %b, want %b", a, b, GG, exp[0]);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        A       = '0;
        B       = '0;
        Ci      = 1'b0;
        #3;
        test_reset();
        test_ripple();
        test_propagate();
        test_max();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
